mem_input_loader: RTL and testbench

//  Front-panel writer into DataMemory: the counterpart of the post-execution memory display path.

---
 rtl/loader_defs_pkg.sv | 33 +++
 rtl/mem_input_loader_debouncer.sv | 49 ++++
 rtl/mem_input_loader.sv | 155 +++++++++++++++
 tb/tb_mem_input_loader.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_defs_pkg.sv
// Shared definitions for the front-panel memory loader and the display address generator.
//   state_t            loader FSM encoding
//   WORD_STRIDE        byte distance between consecutive words
//   DEFAULT_BASE_ADDR  byte address of the first loaded word
//   mem_wr_t           address/data payload of one memory write
package loader_defs;

  localparam int unsigned WORD_W      = 32;
  localparam int unsigned COUNT_W     = 5;
  localparam int unsigned DIGIT_W     = 4;
  localparam int unsigned DISPLAY_W   = 16;
  localparam int unsigned WORD_STRIDE = 4;

  localparam logic [WORD_W-1:0] DEFAULT_BASE_ADDR = 32'h0000_0004;

  typedef enum logic [1:0] {
    ST_ENTRY = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  typedef struct packed {
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] data;
  } mem_wr_t;

  // Byte address of word number idx starting at base.
  function automatic logic [WORD_W-1:0] word_addr(input logic [WORD_W-1:0]  base,
                                                  input logic [COUNT_W-1:0] idx);
    return base + (32'(idx) * 32'(WORD_STRIDE));
  endfunction

endpackage

// File: rtl/mem_input_loader_debouncer.sv
// Button conditioner: 2-FF synchronizer, stability-count debouncer, rising-edge pulse.
//   clk_1k      in  1 kHz clock
//   reset       in  asynchronous, active-high
//   raw         in  raw button level
//   level       out debounced level
//   rise_pulse  out one-cycle pulse per debounced press
module input_debouncer #(
  parameter int unsigned DEBOUNCE_MS = 20
) (
  input  logic clk_1k,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise_pulse
);

  localparam int unsigned CNT_W = (DEBOUNCE_MS < 2) ? 1 : $clog2(DEBOUNCE_MS);

  logic             sync_meta;
  logic             sync_q;
  logic             level_d;
  logic [CNT_W-1:0] stable_cnt;

  // Synchronize, count consecutive samples that disagree with the level, edge-detect.
  always_ff @(posedge clk_1k or posedge reset) begin
    if (reset) begin
      sync_meta  <= 1'b0;
      sync_q     <= 1'b0;
      level      <= 1'b0;
      level_d    <= 1'b0;
      rise_pulse <= 1'b0;
      stable_cnt <= '0;
    end else begin
      sync_meta  <= raw;
      sync_q     <= sync_meta;
      level_d    <= level;
      rise_pulse <= level & ~level_d;
      if (sync_q == level) begin
        stable_cnt <= '0;
      end else if (stable_cnt == CNT_W'(DEBOUNCE_MS - 1)) begin
        level      <= sync_q;
        stable_cnt <= '0;
      end else begin
        stable_cnt <= stable_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/mem_input_loader.sv
// Front-panel writer into data memory: hex digits are shifted into a working word and
// committed to consecutive word addresses; btn_done releases the CPU hold.
//   clk_1k, reset           1 kHz clock, asynchronous active-high reset
//   sw                      hex digit to enter
//   btn_digit/commit/done   raw push buttons
//   mem_write, mem_address, mem_write_data   write port to data memory
//   display_data            low half of the working word (7-seg preview)
//   word_count              words committed so far
//   loading                 high while the CPU must be held
//   start                   one-cycle pulse on leaving load mode
module mem_input_loader
  import loader_defs::*;
#(
  parameter int unsigned       DEBOUNCE_MS = 20,
  parameter logic [31:0]       BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int unsigned       MAX_WORDS   = 16
) (
  input  logic        clk_1k,
  input  logic        reset,
  input  logic [3:0]  sw,
  input  logic        btn_digit,
  input  logic        btn_commit,
  input  logic        btn_done,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic [15:0] display_data,
  output logic [4:0]  word_count,
  output logic        loading,
  output logic        start
);

  logic                digit_pulse;
  logic                commit_pulse;
  logic                done_pulse;
  logic [2:0]          unused_levels;

  logic [DIGIT_W-1:0]  sw_meta;
  logic [DIGIT_W-1:0]  sw_sync;

  state_t              state_q;
  state_t              state_d;
  logic [WORD_W-1:0]   word_q;
  logic [WORD_W-1:0]   word_d;
  logic [COUNT_W-1:0]  count_q;
  logic [COUNT_W-1:0]  count_d;
  mem_wr_t             wr_q;
  mem_wr_t             wr_d;
  logic                mem_write_d;
  logic                loading_d;
  logic                start_d;

  input_debouncer #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_db_digit (
    .clk_1k     (clk_1k),
    .reset      (reset),
    .raw        (btn_digit),
    .level      (unused_levels[0]),
    .rise_pulse (digit_pulse)
  );

  input_debouncer #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_db_commit (
    .clk_1k     (clk_1k),
    .reset      (reset),
    .raw        (btn_commit),
    .level      (unused_levels[1]),
    .rise_pulse (commit_pulse)
  );

  input_debouncer #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_db_done (
    .clk_1k     (clk_1k),
    .reset      (reset),
    .raw        (btn_done),
    .level      (unused_levels[2]),
    .rise_pulse (done_pulse)
  );

  // Digit switches cross into the clk_1k domain.
  always_ff @(posedge clk_1k or posedge reset) begin
    if (reset) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= sw;
      sw_sync <= sw_meta;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk_1k or posedge reset) begin
    if (reset) begin
      state_q   <= ST_ENTRY;
      word_q    <= '0;
      count_q   <= '0;
      wr_q      <= '{addr: BASE_ADDR, data: '0};
      mem_write <= 1'b0;
      loading   <= 1'b1;
      start     <= 1'b0;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      count_q   <= count_d;
      wr_q      <= wr_d;
      mem_write <= mem_write_d;
      loading   <= loading_d;
      start     <= start_d;
    end
  end

  // Next state; same-cycle pulses resolve as done > commit > digit.
  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    count_d     = count_q;
    wr_d        = wr_q;
    mem_write_d = 1'b0;
    loading_d   = loading;
    start_d     = 1'b0;
    unique case (state_q)
      ST_ENTRY: begin
        if (done_pulse) begin
          state_d   = ST_DONE;
          start_d   = 1'b1;
          loading_d = 1'b0;
        end else if (commit_pulse) begin
          // A commit on a full buffer still consumes any coincident digit pulse.
          if (count_q < COUNT_W'(MAX_WORDS)) begin
            wr_d.addr   = word_addr(BASE_ADDR, count_q);
            wr_d.data   = word_q;
            mem_write_d = 1'b1;
            state_d     = ST_WRITE;
          end
        end else if (digit_pulse) begin
          word_d = {word_q[WORD_W-DIGIT_W-1:0], sw_sync};
        end
      end
      ST_WRITE: begin
        count_d = count_q + COUNT_W'(1);
        word_d  = '0;
        state_d = ST_ENTRY;
      end
      ST_DONE: begin
        loading_d = 1'b0;
      end
      default: begin
        state_d = ST_ENTRY;
      end
    endcase
  end

  assign mem_address    = wr_q.addr;
  assign mem_write_data = wr_q.data;
  assign word_count     = count_q;
  assign display_data   = word_q[DISPLAY_W-1:0];

endmodule

// File: tb/tb_mem_input_loader.sv
// Directed bench for mem_input_loader with a short debounce window.
module tb_mem_input_loader;

  localparam int unsigned DB = 3;

  logic        clk_1k = 1'b0;
  logic        reset;
  logic [3:0]  sw;
  logic        btn_digit;
  logic        btn_commit;
  logic        btn_done;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [15:0] display_data;
  logic [4:0]  word_count;
  logic        loading;
  logic        start;

  int n_total = 0;
  int n_pass  = 0;

  // Bench-side observation of strobes.
  int          wr_cnt    = 0;
  int          start_cnt = 0;
  logic [31:0] last_addr = '0;
  logic [31:0] last_data = '0;

  mem_input_loader #(
    .DEBOUNCE_MS (DB),
    .BASE_ADDR   (32'h0000_0004),
    .MAX_WORDS   (16)
  ) dut (
    .clk_1k         (clk_1k),
    .reset          (reset),
    .sw             (sw),
    .btn_digit      (btn_digit),
    .btn_commit     (btn_commit),
    .btn_done       (btn_done),
    .mem_write      (mem_write),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .display_data   (display_data),
    .word_count     (word_count),
    .loading        (loading),
    .start          (start)
  );

  always #5 clk_1k = ~clk_1k;

  always @(negedge clk_1k) begin
    if (mem_write === 1'b1) begin
      wr_cnt    <= wr_cnt + 1;
      last_addr <= mem_address;
      last_data <= mem_write_data;
    end
    if (start === 1'b1) start_cnt <= start_cnt + 1;
  end

  typedef struct {
    int          ndig;
    logic [35:0] digits;
    logic [31:0] exp_word;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_1k);
  endtask

  task automatic press(input logic d, input logic c, input logic dn);
    btn_digit  = d;
    btn_commit = c;
    btn_done   = dn;
    tick(8);
    btn_digit  = 1'b0;
    btn_commit = 1'b0;
    btn_done   = 1'b0;
    tick(8);
  endtask

  task automatic press_digit(input logic [3:0] v);
    sw = v;
    tick(3);
    press(1'b1, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(2);
  endtask

  initial begin
    int w0;
    int s0;
    int n;
    logic [3:0] dg;

    reset      = 1'b1;
    sw         = 4'h0;
    btn_digit  = 1'b0;
    btn_commit = 1'b0;
    btn_done   = 1'b0;
    tick(2);

    // Reset state (still in reset)
    check("rst_loading",   32'(loading), 32'd1);
    check("rst_start",     32'(start), 32'd0);
    check("rst_mem_write", 32'(mem_write), 32'd0);
    check("rst_addr",      mem_address, 32'h4);
    check("rst_data",      mem_write_data, 32'h0);
    check("rst_count",     32'(word_count), 32'd0);
    check("rst_display",   32'(display_data), 32'd0);
    reset = 1'b0;
    tick(2);

    // Digit entry and commit, table driven
    vecs[0] = '{4, 36'h1234,       32'h0000_1234, 32'h0000_0004};
    vecs[1] = '{8, 36'hABCDEF01,   32'hABCD_EF01, 32'h0000_0008};
    vecs[2] = '{9, 36'h987654321,  32'h8765_4321, 32'h0000_000C};
    vecs[3] = '{0, 36'h0,          32'h0000_0000, 32'h0000_0010};
    for (int i = 0; i < 4; i++) begin
      for (int k = vecs[i].ndig - 1; k >= 0; k--) begin
        dg = vecs[i].digits[4*k +: 4];
        press_digit(dg);
      end
      check($sformatf("v%0d_preview", i), 32'(display_data), {16'h0, vecs[i].exp_word[15:0]});
      w0 = wr_cnt;
      press(1'b0, 1'b1, 1'b0);
      check($sformatf("v%0d_writes", i), 32'(wr_cnt - w0), 32'd1);
      check($sformatf("v%0d_addr", i), last_addr, vecs[i].exp_addr);
      check($sformatf("v%0d_data", i), last_data, vecs[i].exp_word);
      check($sformatf("v%0d_count", i), 32'(word_count), 32'(i + 1));
      check($sformatf("v%0d_cleared", i), 32'(display_data), 32'd0);
    end

    // Full buffer: words 5..16, then one ignored commit
    w0 = wr_cnt;
    for (int i = 0; i < 12; i++) press(1'b0, 1'b1, 1'b0);
    check("full_writes", 32'(wr_cnt - w0), 32'd12);
    check("full_last_addr", last_addr, 32'h40);
    check("full_count", 32'(word_count), 32'd16);
    w0 = wr_cnt;
    press(1'b0, 1'b1, 1'b0);
    check("overflow_no_write", 32'(wr_cnt - w0), 32'd0);
    check("overflow_count", 32'(word_count), 32'd16);

    // Bounce rejection: 10 cycles of toggling, then held
    do_reset();
    sw = 4'h5;
    tick(3);
    for (int i = 0; i < 10; i++) begin
      btn_digit = ~btn_digit;
      tick(1);
    end
    btn_digit = 1'b1;
    n = 0;
    while (display_data == 16'h0 && n < 30) begin
      tick(1);
      n++;
    end
    check("bounce_latency", 32'(n), 32'(DB + 4));
    tick(15);
    check("bounce_single_shift", 32'(display_data), 32'h5);
    btn_digit = 1'b0;
    tick(10);
    check("bounce_no_release_shift", 32'(display_data), 32'h5);

    // Simultaneous commit+digit: write wins, digit dropped
    do_reset();
    press_digit(4'h7);
    sw = 4'h3;
    tick(3);
    w0 = wr_cnt;
    press(1'b1, 1'b1, 1'b0);
    check("cd_writes", 32'(wr_cnt - w0), 32'd1);
    check("cd_data", last_data, 32'h7);
    check("cd_display", 32'(display_data), 32'd0);
    check("cd_count", 32'(word_count), 32'd1);
    // Simultaneous done+commit: done wins
    w0 = wr_cnt;
    s0 = start_cnt;
    press(1'b0, 1'b1, 1'b1);
    check("dc_start", 32'(start_cnt - s0), 32'd1);
    check("dc_no_write", 32'(wr_cnt - w0), 32'd0);
    check("dc_loading", 32'(loading), 32'd0);
    check("dc_count", 32'(word_count), 32'd1);

    // Done then idle
    do_reset();
    s0 = start_cnt;
    press(1'b0, 1'b0, 1'b1);
    check("done_start_width", 32'(start_cnt - s0), 32'd1);
    check("done_loading", 32'(loading), 32'd0);
    w0 = wr_cnt;
    s0 = start_cnt;
    press_digit(4'hA);
    press(1'b0, 1'b1, 1'b0);
    press(1'b0, 1'b0, 1'b1);
    check("idle_display", 32'(display_data), 32'd0);
    check("idle_no_write", 32'(wr_cnt - w0), 32'd0);
    check("idle_no_start", 32'(start_cnt - s0), 32'd0);
    check("idle_count", 32'(word_count), 32'd0);
    check("idle_addr", mem_address, 32'h4);
    check("idle_loading", 32'(loading), 32'd0);

    // Reset in the middle of the WRITE cycle
    do_reset();
    press_digit(4'h9);
    btn_commit = 1'b1;
    n = 0;
    while (mem_write !== 1'b1 && n < 30) begin
      tick(1);
      n++;
    end
    check("mid_write_seen", 32'(mem_write), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("mid_write_drop", 32'(mem_write), 32'd0);
    btn_commit = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(2);
    check("mid_count", 32'(word_count), 32'd0);
    check("mid_loading", 32'(loading), 32'd1);
    check("mid_addr", mem_address, 32'h4);
    check("mid_display", 32'(display_data), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
